// File: rtl/axil_snn_ctrl_slave_pkg.sv
// axil_snn_ctrl_slave_pkg: shared register offsets, response codes and channel FSM states
//   for the SNN accelerator AXI4-Lite control slave.
package pa_SnnAccelerator;
    localparam logic [31:0] CTRL_OFF   = 32'h000;
    localparam logic [31:0] STATUS_OFF = 32'h004;
    localparam logic [31:0] RESULT_OFF = 32'h008;
    localparam logic [31:0] CYCLES_OFF = 32'h00C;
    localparam logic [31:0] IMAGE_BASE = 32'h400;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;
endpackage

// File: rtl/axil_snn_ctrl_slave_if.sv
// axil_snn_ctrl_slave_if: AXI4-Lite bus bundle.
//   master: drives AW/W/AR address+data, BREADY, RREADY
//   slave : drives AWREADY, WREADY, B response, ARREADY, R data/response
interface axil_snn_ctrl_slave_if #(
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0] AWADDR;
    logic [2:0]                AWPROT;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [31:0]               WDATA;
    logic [3:0]                WSTRB;
    logic                      WVALID;
    logic                      WREADY;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    logic [AXI_ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]                ARPROT;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [31:0]               RDATA;
    logic [1:0]                RRESP;
    logic                      RVALID;
    logic                      RREADY;
    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_snn_ctrl_regs.sv
// axil_snn_ctrl_regs: address decode, control/status registers and busy-cycle counter.
//   we_i/waddr_i/wdata_i/wstrb_i : one-cycle write execute with captured AW/W, bresp_o its response
//   raddr_i -> rdata_o/rresp_o   : combinational read decode
//   img_*_o, core_start_o        : side effects into the core; spike_*_i : core result
module axil_snn_ctrl_regs
    import pa_SnnAccelerator::*;
#(
    parameter int AW         = 32,
    parameter int IMAGE_SIZE = 256,
    parameter int PIXEL_BITS = 8,
    parameter int NEUR_BITS  = 8,
    localparam int IW        = $clog2(IMAGE_SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            wstrb_i,
    output logic [1:0]            bresp_o,
    input  logic [AW-1:0]         raddr_i,
    output logic [31:0]           rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  img_we_o,
    output logic [IW-1:0]         img_addr_o,
    output logic [PIXEL_BITS-1:0] img_wdata_o,
    output logic                  core_start_o,
    input  logic                  spike_valid_i,
    input  logic [NEUR_BITS-1:0]  spike_neur_i
);
    logic busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [NEUR_BITS-1:0] neur_q, neur_d;
    logic [31:0] cycles_q, cycles_d;
    logic [AW-1:0] wa, ra, w_off, r_off;
    logic w_img, w_ctrl, w_known, r_img, r_known, fire, start, clr;
    logic unused_bits;
    // Low address bits are ignored everywhere; decode on the word-aligned address.
    assign wa      = {waddr_i[AW-1:2], 2'b00};
    assign ra      = {raddr_i[AW-1:2], 2'b00};
    assign w_off   = wa - AW'(IMAGE_BASE);
    assign r_off   = ra - AW'(IMAGE_BASE);
    assign w_img   = wa >= AW'(IMAGE_BASE) && w_off[AW-1:2] < (AW-2)'(IMAGE_SIZE);
    assign r_img   = ra >= AW'(IMAGE_BASE) && r_off[AW-1:2] < (AW-2)'(IMAGE_SIZE);
    assign w_ctrl  = wa == AW'(CTRL_OFF);
    assign w_known = w_img || wa <= AW'(CYCLES_OFF);
    assign r_known = r_img || ra <= AW'(CYCLES_OFF);
    assign fire    = we_i && wstrb_i[0];
    assign start   = fire && w_ctrl && wdata_i[0] && !busy_q;
    assign clr     = fire && w_ctrl && wdata_i[1];
    assign img_we_o     = fire && w_img && !busy_q;
    assign img_addr_o   = w_off[IW+1:2];
    assign img_wdata_o  = wdata_i[PIXEL_BITS-1:0];
    assign core_start_o = start;
    // Pixel writes during a run are refused so the core sees a stable image.
    assign bresp_o = (!w_known || (wstrb_i[0] && w_img && busy_q)) ? RESP_SLVERR : RESP_OKAY;
    assign rresp_o = r_known ? RESP_OKAY : RESP_SLVERR;
    assign rdata_o = ra == AW'(STATUS_OFF) ? {29'd0, busy_q, done_q, !busy_q} :
                     ra == AW'(RESULT_OFF) ? {valid_q, 31'(neur_q)} :
                     ra == AW'(CYCLES_OFF) ? cycles_q : 32'd0;
    assign unused_bits = ^{wdata_i[31:PIXEL_BITS], wstrb_i[3:1], waddr_i[1:0], raddr_i[1:0], w_off, r_off};
    // Ordering inside one cycle: count, then CLR, then spike capture, then START (START wins).
    always_comb begin
        busy_d   = busy_q;
        done_d   = done_q;
        valid_d  = valid_q;
        neur_d   = neur_q;
        cycles_d = busy_q ? (&cycles_q ? cycles_q : cycles_q + 32'd1) : cycles_q;
        if (clr) begin
            done_d   = 1'b0;
            valid_d  = 1'b0;
            neur_d   = '0;
            cycles_d = '0;
        end
        if (busy_q && spike_valid_i) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
            neur_d  = spike_neur_i;
        end
        if (start) begin
            busy_d   = 1'b1;
            done_d   = 1'b0;
            valid_d  = 1'b0;
            neur_d   = '0;
            cycles_d = '0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            neur_q   <= '0;
            cycles_q <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            neur_q   <= neur_d;
            cycles_q <= cycles_d;
        end
    end
endmodule

// File: rtl/axil_snn_ctrl_slave.sv
// axil_snn_ctrl_slave: AXI4-Lite register window into the SNN accelerator core.
//   CLK/RST : clock, synchronous active-high reset
//   bus     : AXI4-Lite slave port (write and read channels run independently)
//   img_*   : pixel write strobe/index/value into core image memory
//   core_*  : run start pulse out, first-spike report in
module axil_snn_ctrl_slave
    import pa_SnnAccelerator::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int IMAGE_SIZE     = 256,
    parameter int PIXEL_BITS     = 8,
    parameter int NEUR_BITS      = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    axil_snn_ctrl_slave_if.slave          bus,
    output logic                          img_we,
    output logic [$clog2(IMAGE_SIZE)-1:0] img_addr,
    output logic [PIXEL_BITS-1:0]         img_wdata,
    output logic                          core_start,
    input  logic                          core_spike_valid,
    input  logic [NEUR_BITS-1:0]          core_spike_neur
);
    wr_state_e w_q, w_d;
    rd_state_e r_q, r_d;
    logic rdy_q, aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic aw_hs, w_hs, ar_hs;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, rdata_q, rdata;
    logic [3:0] wstrb_q;
    logic [1:0] bresp_q, bresp, rresp_q, rresp;
    logic unused_prot;
    // rdy_q keeps the readies low through reset and for the first edge after it.
    assign bus.AWREADY = rdy_q && w_q == W_IDLE && !aw_held_q;
    assign bus.WREADY  = rdy_q && w_q == W_IDLE && !w_held_q;
    assign bus.BVALID  = w_q == W_RESP;
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = rdy_q && r_q == R_IDLE;
    assign bus.RVALID  = r_q == R_DATA;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign aw_hs = bus.AWVALID && bus.AWREADY;
    assign w_hs  = bus.WVALID && bus.WREADY;
    assign ar_hs = bus.ARVALID && bus.ARREADY;
    assign unused_prot = ^{bus.AWPROT, bus.ARPROT};
    always_comb begin
        aw_held_d = w_q != W_EXEC && (aw_held_q || aw_hs);
        w_held_d  = w_q != W_EXEC && (w_held_q || w_hs);
        w_d = (w_q == W_IDLE && aw_held_d && w_held_d) ? W_EXEC :
              (w_q == W_EXEC) ? W_RESP :
              (w_q == W_RESP && bus.BREADY) ? W_IDLE : w_q;
        r_d = ar_hs ? R_DATA : (r_q == R_DATA && bus.RREADY) ? R_IDLE : r_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_q       <= W_IDLE;
            r_q       <= R_IDLE;
            rdy_q     <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            w_q       <= w_d;
            r_q       <= r_d;
            rdy_q     <= 1'b1;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            if (aw_hs) awaddr_q <= bus.AWADDR;
            if (w_hs) begin
                wdata_q <= bus.WDATA;
                wstrb_q <= bus.WSTRB;
            end
            if (w_q == W_EXEC) bresp_q <= bresp;
            // Read data is captured at the AR handshake edge, so it reflects pre-write state.
            if (ar_hs) begin
                rdata_q <= rdata;
                rresp_q <= rresp;
            end
        end
    end
    axil_snn_ctrl_regs #(
        .AW(AXI_ADDR_WIDTH),
        .IMAGE_SIZE(IMAGE_SIZE),
        .PIXEL_BITS(PIXEL_BITS),
        .NEUR_BITS(NEUR_BITS)
    ) u_regs (
        .clk_i(CLK),
        .rst_i(RST),
        .we_i(w_q == W_EXEC),
        .waddr_i(awaddr_q),
        .wdata_i(wdata_q),
        .wstrb_i(wstrb_q),
        .bresp_o(bresp),
        .raddr_i(bus.ARADDR),
        .rdata_o(rdata),
        .rresp_o(rresp),
        .img_we_o(img_we),
        .img_addr_o(img_addr),
        .img_wdata_o(img_wdata),
        .core_start_o(core_start),
        .spike_valid_i(core_spike_valid),
        .spike_neur_i(core_spike_neur)
    );
endmodule

// File: tb/tb_axil_snn_ctrl_slave.sv
// tb_axil_snn_ctrl_slave: directed self-checking bench with response and pixel scoreboards.
module tb_axil_snn_ctrl_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic img_we, core_start, spike_valid;
    logic [7:0] img_addr, img_wdata, spike_neur;
    int n_cmp = 0, n_bad = 0, cyc = 0, start_cyc = 0, start_cnt = 0, exp_starts = 0, img_cnt = 0;
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [15:0] exp_img[$];

    axil_snn_ctrl_slave_if #(.AXI_ADDR_WIDTH(32)) bif ();

    axil_snn_ctrl_slave dut (
        .CLK(clk),
        .RST(rst),
        .bus(bif),
        .img_we(img_we),
        .img_addr(img_addr),
        .img_wdata(img_wdata),
        .core_start(core_start),
        .core_spike_valid(spike_valid),
        .core_spike_neur(spike_neur)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (img_we === 1'b1) begin
            img_cnt++;
            if (exp_img.size() == 0) check("img_unexpected", 32'(img_we), 32'd0);
            else begin
                logic [15:0] e;
                e = exp_img.pop_front();
                check("img_addr", 32'(img_addr), 32'(e[15:8]));
                check("img_wdata", 32'(img_wdata), 32'(e[7:0]));
            end
        end
        if (core_start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic get_b();
        int t = 0;
        logic [1:0] e;
        bif.BREADY = 1'b1;
        while (!bif.BVALID && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("bvalid_seen", 32'(bif.BVALID), 32'd1);
        e = exp_b.pop_front();
        check("bresp", 32'(bif.BRESP), 32'(e));
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input logic [1:0] resp, input bit wait_b);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int t = 0;
        exp_b.push_back(resp);
        while (!(aw_done && w_done) && t < 40) begin
            bif.AWADDR  = a;
            bif.WDATA   = d;
            bif.WSTRB   = s;
            bif.AWVALID = !aw_done && t >= aw_dly;
            bif.WVALID  = !w_done && t >= w_dly;
            hs_aw = bif.AWVALID && bif.AWREADY;
            hs_w  = bif.WVALID && bif.WREADY;
            @(posedge clk); #1;
            aw_done |= hs_aw;
            w_done  |= hs_w;
            t++;
        end
        bif.AWVALID = 1'b0;
        bif.WVALID  = 1'b0;
        check("aw_w_accepted", 32'({aw_done, w_done}), 32'd3);
        if (wait_b) get_b();
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp, input int stall);
        bit done = 0, hs;
        int t = 0;
        logic [33:0] e;
        exp_r.push_back({resp, d});
        bif.ARADDR = a;
        bif.RREADY = 1'b0;
        while (!done && t < 40) begin
            bif.ARVALID = 1'b1;
            hs = bif.ARREADY;
            @(posedge clk); #1;
            done = hs;
            t++;
        end
        bif.ARVALID = 1'b0;
        t = 0;
        while (!bif.RVALID && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("rvalid_seen", 32'(bif.RVALID), 32'd1);
        e = exp_r.pop_front();
        for (int i = 0; i < stall; i++) begin
            check("rdata_stall", bif.RDATA, e[31:0]);
            check("rvalid_stall", 32'(bif.RVALID), 32'd1);
            @(posedge clk); #1;
        end
        check("rdata", bif.RDATA, e[31:0]);
        check("rresp", 32'(bif.RRESP), 32'(e[33:32]));
        bif.RREADY = 1'b1;
        @(posedge clk); #1;
        bif.RREADY = 1'b0;
    endtask

    task automatic wait_bvalid();
        int t = 0;
        while (!bif.BVALID && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
    endtask

    initial begin
        bif.AWADDR = '0; bif.AWPROT = '0; bif.AWVALID = 1'b0;
        bif.WDATA = '0; bif.WSTRB = '0; bif.WVALID = 1'b0; bif.BREADY = 1'b1;
        bif.ARADDR = '0; bif.ARPROT = '0; bif.ARVALID = 1'b0; bif.RREADY = 1'b0;
        spike_valid = 1'b0;
        spike_neur = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({bif.AWREADY, bif.WREADY, bif.ARREADY, bif.BVALID, bif.RVALID, img_we, core_start}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("readies_after_reset", 32'({bif.AWREADY, bif.WREADY, bif.ARREADY}), 32'd7);
        axi_read(32'h004, 32'h1, 2'b00, 0);
        // Pixel write with W ahead of AW
        exp_img.push_back({8'd1, 8'h5A});
        axi_write(32'h404, 32'h5A, 4'hF, 2, 0, 2'b00, 1);
        check("img_drained", 32'(exp_img.size()), 32'd0);
        check("img_count_1", 32'(img_cnt), 32'd1);
        // START with W two cycles after AW
        exp_starts++;
        axi_write(32'h000, 32'h1, 4'hF, 0, 2, 2'b00, 1);
        check("start_count_1", 32'(start_cnt), 32'(exp_starts));
        axi_read(32'h004, 32'h4, 2'b00, 0);
        // Refused pixel write while busy, unmapped read, write-only/self-clearing reads
        axi_write(32'h408, 32'h11, 4'hF, 0, 0, 2'b10, 1);
        check("img_count_busy", 32'(img_cnt), 32'd1);
        axi_read(32'h020, 32'h0, 2'b10, 0);
        axi_read(32'h000, 32'h0, 2'b00, 0);
        axi_read(32'h404, 32'h0, 2'b00, 0);
        // First spike after 50 busy cycles; a later spike must be ignored
        while (cyc < start_cyc + 50) begin
            @(posedge clk); #1;
        end
        spike_valid = 1'b1;
        spike_neur = 8'd7;
        @(posedge clk); #1;
        spike_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        spike_valid = 1'b1;
        spike_neur = 8'd3;
        @(posedge clk); #1;
        spike_valid = 1'b0;
        axi_read(32'h008, 32'h80000007, 2'b00, 0);
        axi_read(32'h004, 32'h3, 2'b00, 0);
        axi_read(32'h00C, 32'd50, 2'b00, 0);
        // CLR wipes result/done/cycles
        axi_write(32'h000, 32'h2, 4'hF, 0, 0, 2'b00, 1);
        axi_read(32'h004, 32'h1, 2'b00, 0);
        axi_read(32'h008, 32'h0, 2'b00, 0);
        axi_read(32'h00C, 32'h0, 2'b00, 0);
        // START without byte 0 strobe has no effect
        axi_write(32'h000, 32'h1, 4'hE, 0, 0, 2'b00, 1);
        check("start_count_nostrb", 32'(start_cnt), 32'(exp_starts));
        axi_read(32'h004, 32'h1, 2'b00, 0);
        // Back-pressured B and R channels
        bif.BREADY = 1'b0;
        axi_write(32'h020, 32'h0, 4'hF, 0, 0, 2'b10, 0);
        wait_bvalid();
        for (int i = 0; i < 5; i++) begin
            check("bvalid_hold", 32'(bif.BVALID), 32'd1);
            check("bresp_hold", 32'(bif.BRESP), 32'd2);
            check("readies_low_hold", 32'({bif.AWREADY, bif.WREADY}), 32'd0);
            @(posedge clk); #1;
        end
        get_b();
        axi_read(32'h004, 32'h1, 2'b00, 4);
        // Reset during W_RESP abandons the response and forgets the run
        bif.BREADY = 1'b0;
        exp_starts++;
        axi_write(32'h000, 32'h1, 4'hF, 0, 0, 2'b00, 0);
        wait_bvalid();
        check("bvalid_before_rst", 32'(bif.BVALID), 32'd1);
        void'(exp_b.pop_front());
        rst = 1'b1;
        @(posedge clk); #1;
        check("bvalid_after_rst", 32'(bif.BVALID), 32'd0);
        rst = 1'b0;
        bif.BREADY = 1'b1;
        @(posedge clk); #1;
        check("start_count_2", 32'(start_cnt), 32'(exp_starts));
        axi_read(32'h004, 32'h1, 2'b00, 0);
        // START then CLR: run keeps going, result cleared
        exp_starts++;
        axi_write(32'h000, 32'h1, 4'hF, 0, 0, 2'b00, 1);
        axi_write(32'h000, 32'h2, 4'hF, 0, 0, 2'b00, 1);
        axi_read(32'h004, 32'h4, 2'b00, 0);
        axi_read(32'h008, 32'h0, 2'b00, 0);
        // START|CLR while busy: START ignored
        axi_write(32'h000, 32'h3, 4'hF, 0, 0, 2'b00, 1);
        check("start_count_final", 32'(start_cnt), 32'(exp_starts));
        check("img_count_final", 32'(img_cnt), 32'd1);
        check("b_queue_empty", 32'(exp_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
